// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - sync + debounce for four sensors and the silence button, with a stretched silence level.
// Define SENSOR_LATCH_EN to hold each risen sensor bit until the next accepted silence press.
`timescale 1ns/1ps
module sensor_conditioner #(
    parameter int DB_CYCLES = 16,
    parameter int SIL_HOLD  = 4
) (
    input  logic       CLK_ROSHI,
    input  logic       reset,
    input  logic [3:0] sens_raw,
    input  logic       btn_sil_raw,
    output logic [3:0] sensores,
    output logic       silenciar,
    output logic       sens_evt
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam int SW = $clog2(SIL_HOLD + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [SW-1:0] SIL_LOAD = SW'(SIL_HOLD);

    // Channel 4 is the silence button, channels 3..0 the sensors.
    logic [4:0]    raw_all;
    logic [4:0]    s1, s2, db, db_nxt;
    logic [CW-1:0] cnt     [5];
    logic [CW-1:0] cnt_nxt [5];
    logic [3:0]    sens_rise;
    logic          btn_q;
    logic          sil_load;
    logic [SW-1:0] sil_cnt;

    assign raw_all = {btn_sil_raw, sens_raw};

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            db_nxt[i]  = db[i];
            cnt_nxt[i] = '0;
            if (s2[i] != db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK_ROSHI) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            db <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw_all;
            s2 <= s1;
            db <= db_nxt;
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign sens_rise = db_nxt[3:0] & ~db[3:0];

    always_ff @(posedge CLK_ROSHI) begin
        if (reset) begin
            sens_evt <= 1'b0;
        end else begin
            sens_evt <= |sens_rise;
        end
    end

    // Press detection uses the registered button level, so the stretch starts one edge after db_btn rises.
    assign sil_load = db[4] & ~btn_q;

    always_ff @(posedge CLK_ROSHI) begin
        if (reset) begin
            btn_q   <= 1'b0;
            sil_cnt <= '0;
        end else begin
            btn_q <= db[4];
            if (sil_load) begin
                sil_cnt <= SIL_LOAD;
            end else if (sil_cnt != '0) begin
                sil_cnt <= sil_cnt - SW'(1);
            end
        end
    end

    assign silenciar = (sil_cnt != '0);

`ifdef SENSOR_LATCH_EN
    logic [3:0] lat;

    // A rise on the same edge as the clear wins, so it is ORed in after the clear.
    always_ff @(posedge CLK_ROSHI) begin
        if (reset) begin
            lat <= '0;
        end else begin
            lat <= (sil_load ? 4'b0000 : lat) | sens_rise;
        end
    end

    assign sensores = db[3:0] | lat;
`else
    assign sensores = db[3:0];
`endif

endmodule
